hamming_decode_engine: RTL and testbench

Hardware SECDED decoder for the Hamming(16,11) words produced by the program-1 encoder. It sits beside the data memory in the top level as a memory master. On `start` it walks a block of encoded 16-bit words and reconstructs each 11-bit message. It corrects single-bit errors, flags double-bit errors, writes the results back to memory and raises `done`.

---
 rtl/hamming_decode_engine_if.sv | 22 ++
 rtl/hamming_decode_engine.sv | 145 ++++++++++++++
 tb/tb_hamming_decode_engine.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_decode_engine_if.sv
// Byte-wide memory port shared by the decode engine (master) and the data
// memory (slave). Read data is combinational for the address driven this cycle.
interface hamming_decode_engine_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/hamming_decode_engine.sv
// SECDED decoder for a block of Hamming(16,11) words held in byte memory.
// Each word is read as two bytes, corrected or flagged, and written back as
// {flags, data} in two bytes. Five cycles per word; done is held until the
// next start.
module hamming_decode_engine #(
    parameter int         NUM_WORDS = 15,
    parameter logic [7:0] SRC_BASE  = 8'd30,
    parameter logic [7:0] DST_BASE  = 8'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           done,
    output logic [3:0]                     single_cnt,
    output logic [3:0]                     double_cnt,
    hamming_decode_engine_if.master        mem
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_LO  = 3'd1;
    localparam logic [2:0] S_RD_HI  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_WR_LO  = 3'd4;
    localparam logic [2:0] S_WR_HI  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    logic [2:0]  state;
    logic [7:0]  idx;
    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [7:0]  out_lo;
    logic [7:0]  out_hi;

    logic [15:0] cw;
    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;
    logic [10:0] data;
    logic        flag_single;
    logic        flag_double;
    logic        unused_parity_bits;

    logic [7:0]  word_off;
    logic        last_word;

    // Each word occupies two bytes; offsets wrap with the 8-bit address space.
    assign word_off  = {idx[6:0], 1'b0};
    assign last_word = (idx == LAST_IDX);
    assign done      = (state == S_DONE);

    // Syndrome, overall parity and single-bit correction of the captured word.
    always_comb begin
        cw  = {hi_byte, lo_byte};
        // Syndrome bit b is the parity of every position whose index has bit b set.
        syn = {^(cw & 16'hFF00), ^(cw & 16'hF0F0), ^(cw & 16'hCCCC), ^(cw & 16'hAAAA)};
        par = ^cw;
        // syn == 0 with odd parity flips only p0, which never reaches the data.
        fixed       = par ? (cw ^ (16'h0001 << syn)) : cw;
        data        = {fixed[15:9], fixed[7:5], fixed[3]};
        flag_single = par;
        flag_double = !par && (syn != 4'd0);
    end

    // Parity positions are dropped once correction is done.
    assign unused_parity_bits = ^{fixed[8], fixed[4], fixed[2:0]};

    // Moore memory-port outputs decoded from the current state and index.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        mem.mem_addr    = 8'd0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = 8'd0;
        case (state)
            S_RD_LO: mem.mem_addr = SRC_BASE + word_off;
            S_RD_HI: mem.mem_addr = SRC_BASE + word_off + 8'd1;
            S_WR_LO: begin
                mem.mem_addr    = DST_BASE + word_off;
                mem.mem_wr_en   = 1'b1;
                mem.mem_wr_data = out_lo;
            end
            S_WR_HI: begin
                mem.mem_addr    = DST_BASE + word_off + 8'd1;
                mem.mem_wr_en   = 1'b1;
                mem.mem_wr_data = out_hi;
            end
            default: ;
        endcase
    end

    // Sequencer, byte capture, result registers and saturating error counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 8'd0;
            lo_byte    <= 8'd0;
            hi_byte    <= 8'd0;
            out_lo     <= 8'd0;
            out_hi     <= 8'd0;
            single_cnt <= 4'd0;
            double_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RD_LO;
                        idx        <= 8'd0;
                        single_cnt <= 4'd0;
                        double_cnt <= 4'd0;
                    end
                end
                S_RD_LO: begin
                    lo_byte <= mem.mem_rd_data;
                    state   <= S_RD_HI;
                end
                S_RD_HI: begin
                    hi_byte <= mem.mem_rd_data;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    out_lo <= data[7:0];
                    out_hi <= {flag_double, flag_single, 3'b000, data[10:8]};
                    if (flag_single && single_cnt != 4'hF)
                        single_cnt <= single_cnt + 4'd1;
                    if (flag_double && double_cnt != 4'hF)
                        double_cnt <= double_cnt + 4'd1;
                    state <= S_WR_LO;
                end
                S_WR_LO: state <= S_WR_HI;
                S_WR_HI: begin
                    if (last_word) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_RD_LO;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_decode_engine.sv
// Randomised and directed bench for hamming_decode_engine with a byte memory
// model and a position-level Hamming encoder/decoder reference.
module tb_hamming_decode_engine;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       done;
    logic [3:0] single_cnt;
    logic [3:0] double_cnt;

    hamming_decode_engine_if bus();

    hamming_decode_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .single_cnt (single_cnt),
        .double_cnt (double_cnt),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    // Byte memory with a loader port for the bench and write tracking per run.
    logic [7:0] mem [256];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'd0;
    logic [7:0] load_data = 8'd0;
    int         run_tag = 0;
    int         wr_tag [256];
    int         wr_cnt = 0;
    int         wr_oob = 0;
    int         wr_dup = 0;

    assign bus.mem_rd_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_cnt <= wr_cnt + 1;
            if (int'(bus.mem_addr) < DST || int'(bus.mem_addr) >= DST + 2 * NW)
                wr_oob <= wr_oob + 1;
            if (wr_tag[bus.mem_addr] == run_tag)
                wr_dup <= wr_dup + 1;
            wr_tag[bus.mem_addr] <= run_tag;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_lo [NW];
    logic [7:0] exp_hi [NW];
    int         exp_single;
    int         exp_double;
    int         wr_cnt0, wr_oob0, wr_dup0;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 1; k < 16; k++)
            if (w[k]) s = s ^ 4'(k);
        return s;
    endfunction

    function automatic logic [15:0] ref_encode(input logic [10:0] m);
        logic [15:0] w;
        logic [3:0]  s;
        int          j;
        w = 16'd0;
        j = 0;
        for (int k = 1; k < 16; k++)
            if ((k & (k - 1)) != 0) begin
                w[k] = m[j];
                j++;
            end
        s = ref_syndrome(w);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[1 << b] = 1'b1;
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] ref_extract(input logic [15:0] w);
        logic [10:0] m;
        int          j;
        m = 11'd0;
        j = 0;
        for (int k = 1; k < 16; k++)
            if ((k & (k - 1)) != 0) begin
                m[j] = w[k];
                j++;
            end
        return m;
    endfunction

    // ---------------- helpers ----------------
    task automatic load_byte(input int a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 8'(a);
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic load_word(input int i, input logic [15:0] w);
        load_byte(SRC + 2 * i, w[7:0]);
        load_byte(SRC + 2 * i + 1, w[15:8]);
    endtask

    task automatic clear_dst();
        for (int a = DST; a < DST + 2 * NW; a++) load_byte(a, 8'hAA);
    endtask

    // Random messages, each with 0, 1 or 2 distinct bit flips; expectations from the spec rules.
    task automatic prepare_random();
        logic [10:0] m;
        logic [15:0] w;
        int          nflip, b1, b2;
        exp_single = 0;
        exp_double = 0;
        for (int i = 0; i < NW; i++) begin
            m     = 11'($urandom);
            w     = ref_encode(m);
            nflip = int'($urandom_range(0, 2));
            b1    = int'($urandom_range(0, 15));
            b2    = (b1 + int'($urandom_range(1, 15))) % 16;
            if (nflip >= 1) w[b1] = ~w[b1];
            if (nflip == 2) w[b2] = ~w[b2];
            if (nflip == 2) m = ref_extract(w);
            exp_lo[i] = m[7:0];
            exp_hi[i] = {nflip == 2, nflip == 1, 3'b000, m[10:8]};
            if (nflip == 1) exp_single++;
            if (nflip == 2) exp_double++;
            load_word(i, w);
        end
        if (exp_single > 15) exp_single = 15;
        if (exp_double > 15) exp_double = 15;
        clear_dst();
    endtask

    // Pulses start, optionally re-pulses it mid-run, and measures edges until done.
    task automatic run_engine(input string name, input int busy_edge);
        int lat;
        run_tag++;
        wr_cnt0 = wr_cnt;
        wr_oob0 = wr_oob;
        wr_dup0 = wr_dup;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_after_start: got %b want 0", name, done);
        end
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            start = (n == busy_edge);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != NW * 5) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, lat, NW * 5);
        end
    endtask

    task automatic check_results(input string name);
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (mem[DST + 2 * i] !== exp_lo[i] || mem[DST + 2 * i + 1] !== exp_hi[i]) begin
                errors++;
                $display("FAIL %s word%0d: got %h_%h want %h_%h", name, i,
                         mem[DST + 2 * i + 1], mem[DST + 2 * i], exp_hi[i], exp_lo[i]);
            end
        end
        checks++;
        if (int'(single_cnt) != exp_single || int'(double_cnt) != exp_double) begin
            errors++;
            $display("FAIL %s counters: got s=%0d d=%0d want s=%0d d=%0d", name,
                     single_cnt, double_cnt, exp_single, exp_double);
        end
        checks++;
        if (wr_cnt - wr_cnt0 != 2 * NW || wr_oob != wr_oob0 || wr_dup != wr_dup0) begin
            errors++;
            $display("FAIL %s writes: got n=%0d oob=%0d dup=%0d want n=%0d oob=0 dup=0", name,
                     wr_cnt - wr_cnt0, wr_oob - wr_oob0, wr_dup - wr_dup0, 2 * NW);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 8'd0 ||
            bus.mem_wr_data !== 8'd0 || single_cnt !== 4'd0 || double_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got done=%b we=%b addr=%h wd=%h s=%0d d=%0d want all 0",
                     done, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, single_cnt, double_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] words [4];
        logic [7:0]  want_lo [4];
        logic [7:0]  want_hi [4];
        int          want_s [4];
        int          want_d [4];
        words   = '{16'hFFFF, 16'hFFDF, 16'h0001, 16'h0208};
        want_lo = '{8'hFF, 8'hFF, 8'h00, 8'h11};
        want_hi = '{8'h07, 8'h47, 8'h40, 8'h80};
        want_s  = '{0, 1, 1, 0};
        want_d  = '{0, 0, 0, 1};
        for (int i = 1; i < NW; i++) load_word(i, 16'h0000);
        for (int t = 0; t < 4; t++) begin
            load_word(0, words[t]);
            clear_dst();
            run_engine($sformatf("directed%0d", t), 0);
            checks++;
            if (mem[DST] !== want_lo[t] || mem[DST + 1] !== want_hi[t]) begin
                errors++;
                $display("FAIL directed%0d bytes: got %h,%h want %h,%h", t,
                         mem[DST], mem[DST + 1], want_lo[t], want_hi[t]);
            end
            checks++;
            if (int'(single_cnt) != want_s[t] || int'(double_cnt) != want_d[t]) begin
                errors++;
                $display("FAIL directed%0d counters: got s=%0d d=%0d want s=%0d d=%0d", t,
                         single_cnt, double_cnt, want_s[t], want_d[t]);
            end
        end
    endtask

    task automatic test_full_run();
        for (int r = 0; r < 3; r++) begin
            prepare_random();
            run_engine($sformatf("random%0d", r), 0);
            check_results($sformatf("random%0d", r));
        end
    endtask

    task automatic test_restart_from_done();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_hold_done: got %b want 1", done);
        end
        prepare_random();
        run_engine("restart", 0);
        check_results("restart");
    endtask

    task automatic test_reset_mid_run();
        int wr_snap;
        prepare_random();
        run_tag++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 8'd0 ||
            single_cnt !== 4'd0 || double_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset: got done=%b we=%b addr=%h s=%0d d=%0d want all 0",
                     done, bus.mem_wr_en, bus.mem_addr, single_cnt, double_cnt);
        end
        @(negedge clk);
        reset   = 1'b0;
        start   = 1'b0;
        wr_snap = wr_cnt;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != wr_snap || done !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got writes=%0d done=%b want 0 and 0",
                     wr_cnt - wr_snap, done);
        end
        prepare_random();
        run_engine("after_reset_busy_start", 37);
        check_results("after_reset_busy_start");
    endtask

    initial begin
        for (int a = 0; a < 256; a++) wr_tag[a] = -1;
        test_reset();
        test_directed();
        test_full_run();
        test_restart_from_done();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
